// File: rtl/time_counter_bcd_pkg.sv
// Shared timekeeping definitions: BCD digit widths, digit limits and a
// legality helper used by every counter in the clock.
package time_counter_bcd_pkg;

    localparam int unsigned TENS_W   = 3;
    localparam int unsigned UNITS_W  = 4;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    // Two BCD digits kept together so a counter can be handled as one value.
    typedef struct packed {
        logic [TENS_W-1:0]  tens;
        logic [UNITS_W-1:0] units;
    } bcd2_t;

    // True when the pair is a valid BCD number no larger than max.
    function automatic logic bcd_legal(input bcd2_t v, input int unsigned max);
        int unsigned value;
        value = 32'(v.tens) * 32'd10 + 32'(v.units);
        return (v.units <= 4'd9) && (value <= max);
    endfunction

endpackage

// File: rtl/time_counter_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX back to 00. carry_out is a
// same-cycle pulse so that a whole chain of counters rolls over on one edge.
module bcd_mod_counter
    import time_counter_bcd_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic               carry_out,
    output logic [TENS_W-1:0]  tens,
    output logic [UNITS_W-1:0] units
);

    localparam logic [TENS_W-1:0]  MAX_TENS  = TENS_W'(MAX / 10);
    localparam logic [UNITS_W-1:0] MAX_UNITS = UNITS_W'(MAX % 10);

    bcd2_t cnt_q;
    bcd2_t cnt_d;

    // Next count: scrub illegal contents, otherwise step and wrap on inc.
    always_comb begin
        cnt_d     = cnt_q;
        carry_out = 1'b0;
        if (!bcd_legal(cnt_q, MAX)) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q.tens == MAX_TENS && cnt_q.units == MAX_UNITS) begin
                cnt_d     = '0;
                carry_out = 1'b1;
            end else if (cnt_q.units == 4'd9) begin
                cnt_d.units = '0;
                cnt_d.tens  = cnt_q.tens + 1'b1;
            end else begin
                cnt_d.units = cnt_q.units + 1'b1;
            end
        end
    end

    // Count register with synchronous reset to 00.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tens  = cnt_q.tens;
    assign units = cnt_q.units;

endmodule

// File: rtl/time_counter_bcd.sv
// Real-time HH:MM:SS core: 1 Hz prescaler, debounced-button edge detection
// for manual hour/minute adjust, and three chained BCD counters.
module time_counter_bcd
    import time_counter_bcd_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic               run,
    input  logic               inc_min,
    input  logic               inc_hour,
    output logic               sec_tick,
    output logic [TENS_W-1:0]  a1,
    output logic [UNITS_W-1:0] a2,
    output logic [TENS_W-1:0]  a3,
    output logic [UNITS_W-1:0] a4,
    output logic [TENS_W-1:0]  s_tens,
    output logic [UNITS_W-1:0] s_units
);

    localparam int unsigned     CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;
    logic             sec_tick_q;
    logic             inc_min_q;
    logic             inc_min_prev_q;
    logic             inc_hour_q;
    logic             inc_hour_prev_q;

    logic tick;
    logic min_edge;
    logic hour_edge;
    logic sec_carry;
    logic min_carry;
    logic min_inc;
    logic hour_inc;
    logic hour_carry_unused;

    assign tick      = run && (presc_q == LAST);
    assign min_edge  = inc_min_q & ~inc_min_prev_q;
    assign hour_edge = inc_hour_q & ~inc_hour_prev_q;

    // Prescaler advances only while running and wraps at the terminal count.
    always_comb begin
        presc_d = presc_q;
        if (run) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Prescaler, tick pulse and button history registers.
    always_ff @(posedge mclk) begin
        if (rst) begin
            presc_q         <= '0;
            sec_tick_q      <= 1'b0;
            inc_min_q       <= 1'b0;
            inc_min_prev_q  <= 1'b0;
            inc_hour_q      <= 1'b0;
            inc_hour_prev_q <= 1'b0;
        end else begin
            presc_q         <= presc_d;
            sec_tick_q      <= tick;
            inc_min_q       <= inc_min;
            inc_min_prev_q  <= inc_min_q;
            inc_hour_q      <= inc_hour;
            inc_hour_prev_q <= inc_hour_q;
        end
    end

    // A manual minute step in the same cycle as a seconds rollover is one
    // step total, and a wrap caused by the button never carries into hours.
    assign min_inc  = sec_carry | min_edge;
    assign hour_inc = (min_carry & ~min_edge) | hour_edge;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk       (mclk),
        .rst       (rst),
        .inc       (tick),
        .carry_out (sec_carry),
        .tens      (s_tens),
        .units     (s_units)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk       (mclk),
        .rst       (rst),
        .inc       (min_inc),
        .carry_out (min_carry),
        .tens      (a3),
        .units     (a4)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk       (mclk),
        .rst       (rst),
        .inc       (hour_inc),
        .carry_out (hour_carry_unused),
        .tens      (a1),
        .units     (a2)
    );

    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_counter_bcd.sv
// Bench for time_counter_bcd: hand-derived vector table, directed corner
// sequences and randomized stimulus against a seconds/minutes/hours model.
module tb_time_counter_bcd;

    localparam int TPS = 4;

    logic       mclk = 1'b0;
    logic       rst, run, inc_min, inc_hour;
    logic       sec_tick;
    logic [2:0] a1, a3, s_tens;
    logic [3:0] a2, a4, s_units;

    int checks = 0;
    int errors = 0;

    time_counter_bcd #(.TICKS_PER_SEC(TPS)) dut (
        .mclk     (mclk),
        .rst      (rst),
        .run      (run),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .sec_tick (sec_tick),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .a4       (a4),
        .s_tens   (s_tens),
        .s_units  (s_units)
    );

    always #5 mclk = ~mclk;

    logic [21:0] dut_vec;
    assign dut_vec = {sec_tick, a1, a2, a3, a4, s_tens, s_units};

    function automatic logic [21:0] pack(input logic t, input int h, input int m, input int s);
        return {t, 3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    // Reference model: time of day as plain integers.
    int   m_presc, m_hh, m_mm, m_ss;
    logic m_tick, m_min_q, m_min_prev, m_hour_q, m_hour_prev;

    always @(posedge mclk) begin
        logic t, me, he, sec_wrap, min_step, min_wrap;
        if (rst) begin
            m_presc = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_tick = 0;
            m_min_q = 0; m_min_prev = 0; m_hour_q = 0; m_hour_prev = 0;
        end else begin
            t  = run && (m_presc == TPS - 1);
            me = m_min_q && !m_min_prev;
            he = m_hour_q && !m_hour_prev;
            if (run) m_presc = t ? 0 : m_presc + 1;
            sec_wrap = t && (m_ss == 59);
            if (t) m_ss = (m_ss + 1) % 60;
            min_step = sec_wrap || me;
            min_wrap = min_step && (m_mm == 59);
            if (min_step) m_mm = (m_mm + 1) % 60;
            if ((min_wrap && !me) || he) m_hh = (m_hh + 1) % 24;
            m_tick      = t;
            m_min_prev  = m_min_q;  m_min_q  = inc_min;
            m_hour_prev = m_hour_q; m_hour_q = inc_hour;
        end
    end

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_reached(input string name, input logic ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=timeout required=reached at %0t", name, $time);
        end
    endtask

    // One clock, then compare the whole output word against the model.
    task automatic step();
        @(posedge mclk);
        @(negedge mclk);
        check("model", dut_vec, pack(m_tick, m_hh, m_mm, m_ss));
    endtask

    task automatic pulse_min();
        inc_min = 1'b1; step(); inc_min = 1'b0; step(); step();
    endtask

    task automatic pulse_hour();
        inc_hour = 1'b1; step(); inc_hour = 1'b0; step(); step();
    endtask

    task automatic set_hm(input int h, input int m);
        int nh, nm;
        run = 1'b0;
        nh = (h - m_hh + 24) % 24;
        nm = (m - m_mm + 60) % 60;
        for (int i = 0; i < nh; i++) pulse_hour();
        for (int i = 0; i < nm; i++) pulse_min();
    endtask

    typedef struct {
        logic rst, run, im, ih;
        int   n;
        int   h, m, s;
        logic tick;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [21:0] frozen;
        int budget;

        rst = 1'b1; run = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;

        vt[0] = '{1, 0, 0, 0,  2,  0,  0,  0, 0};
        vt[1] = '{0, 1, 0, 0, 40,  0,  0, 10, 1};
        vt[2] = '{0, 0, 0, 1,  3,  1,  0, 10, 0};
        vt[3] = '{0, 0, 0, 0,  2,  1,  0, 10, 0};
        vt[4] = '{0, 0, 1, 0,  3,  1,  1, 10, 0};
        vt[5] = '{0, 0, 0, 0,  2,  1,  1, 10, 0};
        vt[6] = '{0, 0, 1, 1,  3,  2,  2, 10, 0};
        vt[7] = '{0, 0, 0, 0,  2,  2,  2, 10, 0};
        vt[8] = '{0, 1, 0, 0,  3,  2,  2, 10, 0};
        vt[9] = '{0, 1, 0, 0,  1,  2,  2, 11, 1};

        @(negedge mclk);
        for (int i = 0; i < 10; i++) begin
            rst = vt[i].rst; run = vt[i].run; inc_min = vt[i].im; inc_hour = vt[i].ih;
            repeat (vt[i].n) step();
            check($sformatf("vec%0d", i), dut_vec, pack(vt[i].tick, vt[i].h, vt[i].m, vt[i].s));
        end
        inc_min = 1'b0; inc_hour = 1'b0;

        // Full-day rollover 23:59:59 -> 00:00:00 on a single edge.
        set_hm(23, 59);
        run = 1'b1;
        budget = 0;
        while (!(m_ss == 59 && m_presc == TPS - 1) && budget < 400) begin step(); budget++; end
        expect_reached("reach_235959", budget < 400);
        step();
        check("midnight_wrap", dut_vec, pack(1, 0, 0, 0));

        // Held inc_min is one edge only, and a button wrap never carries.
        set_hm(12, 59);
        inc_min = 1'b1;
        repeat (2) step();
        check("hold_min_early", dut_vec, pack(0, 12, 0, 0));
        repeat (8) step();
        inc_min = 1'b0;
        repeat (2) step();
        check("hold_min_no_carry", dut_vec, pack(0, 12, 0, 0));

        // Button edge coincident with the seconds rollover: one minute step.
        set_hm(10, 15);
        run = 1'b1;
        budget = 0;
        while (!(m_ss == 59 && m_presc == 2) && budget < 400) begin step(); budget++; end
        expect_reached("reach_101559", budget < 400);
        inc_min = 1'b1;
        step();
        step();
        check("coincident_min", dut_vec, pack(1, 10, 16, 0));
        inc_min = 1'b0;
        repeat (2) step();

        // Pause mid-second and resume.
        budget = 0;
        while (m_presc != 2 && budget < 10) begin step(); budget++; end
        expect_reached("reach_presc2", budget < 10);
        run = 1'b0;
        frozen = pack(0, m_hh, m_mm, m_ss);
        for (int i = 0; i < 20; i++) begin
            step();
            check("frozen", dut_vec, frozen);
        end
        run = 1'b1;
        step();
        check("resume_no_tick", {21'b0, sec_tick}, 22'd0);
        step();
        check("resume_tick", {21'b0, sec_tick}, 22'd1);

        // Reset mid-second at 17:43:21.
        set_hm(17, 43);
        run = 1'b1;
        budget = 0;
        while (m_ss != 21 && budget < 400) begin step(); budget++; end
        expect_reached("reach_174321", budget < 400);
        check("pre_reset_time", {1'b0, dut_vec[20:0]}, pack(0, 17, 43, 21));
        rst = 1'b1;
        step();
        check("reset_clear", dut_vec, pack(0, 0, 0, 0));
        rst = 1'b0;
        repeat (3) step();
        check("post_reset_no_tick", dut_vec, pack(0, 0, 0, 0));
        step();
        check("post_reset_tick", dut_vec, pack(1, 0, 0, 1));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) inc_min  = ~inc_min;
            if ($urandom_range(0, 9) == 0) inc_hour = ~inc_hour;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
